wb_write_buffer: RTL and testbench

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

---
 rtl/wb_write_buffer.sv | 114 +++++++++++
 tb/tb_wb_write_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_buffer.sv
// Write-back buffer: circular FIFO of (dest, value) results draining one per cycle
// into the register file, with youngest-match operand forwarding from stored entries.
module wb_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_val,
  output logic        in_ready,
  output logic        Write_EN,
  output logic [4:0]  dest,
  output logic [31:0] Write_val,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_val,
  output logic [31:0] fwd2_val,
  output logic [4:0]  count
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [4:0]       ent_dest_q [DEPTH];
  logic [4:0]       ent_dest_d [DEPTH];
  logic [31:0]      ent_val_q  [DEPTH];
  logic [31:0]      ent_val_d  [DEPTH];

  logic push;
  logic pop;

  // Writes to register 0 are accepted on the handshake but never stored.
  assign in_ready = (cnt_q < DEPTH_C);
  assign push     = in_valid && in_ready && (in_dest != 5'd0);
  assign pop      = (cnt_q != 5'd0);

  assign Write_EN  = pop;
  assign dest      = pop ? ent_dest_q[rd_ptr_q] : 5'd0;
  assign Write_val = pop ? ent_val_q[rd_ptr_q]  : 32'd0;
  assign count     = cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ent_vld_d  = ent_vld_q;
    ent_dest_d = ent_dest_q;
    ent_val_d  = ent_val_q;
    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_dest_d[wr_ptr_q] = in_dest;
      ent_val_d[wr_ptr_q]  = in_val;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Scan from head (oldest) towards tail so the youngest match is the last one kept.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1_hit = 1'b0;
    fwd2_hit = 1'b0;
    fwd1_val = 32'd0;
    fwd2_val = 32'd0;
    idx      = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (ent_vld_q[idx] && (src1 != 5'd0) && (ent_dest_q[idx] == src1)) begin
        fwd1_hit = 1'b1;
        fwd1_val = ent_val_q[idx];
      end
      if (ent_vld_q[idx] && (src2 != 5'd0) && (ent_dest_q[idx] == src2)) begin
        fwd2_hit = 1'b1;
        fwd2_val = ent_val_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ent_vld_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ent_vld_q <= ent_vld_d;
    end
  end

  // Payload storage needs no reset; validity bits gate every use of it.
  always_ff @(posedge clk) begin
    ent_dest_q <= ent_dest_d;
    ent_val_q  <= ent_val_d;
  end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Randomized scoreboard bench for wb_write_buffer against a queue-based reference model.
module tb_wb_write_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_dest;
  logic [31:0] in_val;
  logic        in_ready;
  logic        Write_EN;
  logic [4:0]  dest;
  logic [31:0] Write_val;
  logic [4:0]  src1, src2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_val, fwd2_val;
  logic [4:0]  count;

  wb_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_dest(in_dest), .in_val(in_val), .in_ready(in_ready),
    .Write_EN(Write_EN), .dest(dest), .Write_val(Write_val),
    .src1(src1), .src2(src2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_val(fwd1_val), .fwd2_val(fwd2_val),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t pend[$];   // entries the buffer should hold right now
  ent_t sb[$];     // expected register-file write stream

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fwd_ref(input logic [4:0] s, output logic hit, output logic [31:0] v);
    hit = 1'b0;
    v   = 32'd0;
    if (s != 5'd0) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].d == s) begin
          hit = 1'b1;
          v   = pend[i].v;
          break;
        end
      end
    end
  endfunction

  // Monitor: every register-file write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst && Write_EN) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, dest}, 32'hFFFF_FFFF);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("wr_dest", {27'd0, dest}, {27'd0, e.d});
        chk("wr_val", Write_val, e.v);
      end
    end
  end

  // One cycle: called just after a rising edge; returns just after the next one.
  task automatic step(input bit v, input logic [4:0] d, input logic [31:0] val,
                      input logic [4:0] s1, input logic [4:0] s2);
    logic        h1, h2;
    logic [31:0] v1, v2;
    bit          acc;
    in_valid = v;
    in_dest  = d;
    in_val   = val;
    src1     = s1;
    src2     = s2;
    #1;
    fwd_ref(s1, h1, v1);
    fwd_ref(s2, h2, v2);
    chk("fwd1_hit", {31'd0, fwd1_hit}, {31'd0, h1});
    chk("fwd1_val", fwd1_val, v1);
    chk("fwd2_hit", {31'd0, fwd2_hit}, {31'd0, h2});
    chk("fwd2_val", fwd2_val, v2);
    chk("in_ready", {31'd0, in_ready}, {31'd0, pend.size() < DEPTH});
    acc = v && (pend.size() < DEPTH);
    @(posedge clk);
    if (pend.size() != 0) void'(pend.pop_front());
    if (acc && d != 5'd0) begin
      pend.push_back('{d, val});
      sb.push_back('{d, val});
    end
    #1;
    chk("count", {27'd0, count}, pend.size());
    chk("write_en", {31'd0, Write_EN}, {31'd0, pend.size() != 0});
    if (pend.size() == 0) begin
      chk("idle_dest", {27'd0, dest}, 32'd0);
      chk("idle_wval", Write_val, 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen"}, {31'd0, Write_EN}, 32'd0);
    chk({tag, "_count"}, {27'd0, count}, 32'd0);
    chk({tag, "_dest"}, {27'd0, dest}, 32'd0);
    chk({tag, "_wval"}, Write_val, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_fwd1"}, {31'd0, fwd1_hit}, 32'd0);
    chk({tag, "_fwd1v"}, fwd1_val, 32'd0);
  endtask

  task automatic rand_steps(input int n);
    for (int k = 0; k < n; k++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_dest  = 5'd0;
    in_val   = 32'd0;
    src1     = 5'd7;
    src2     = 5'd5;
    #1;
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single write lands on the register-file port one cycle later.
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    chk("single_wen", {31'd0, Write_EN}, 32'd1);
    chk("single_dest", {27'd0, dest}, 32'd5);
    chk("single_wval", Write_val, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("single_done", {31'd0, Write_EN}, 32'd0);

    // Two writes to the same register: forwarding sees the younger value.
    step(1'b1, 5'd7, 32'd1, 5'd7, 5'd0);
    step(1'b1, 5'd7, 32'd2, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);

    // Register 0 is swallowed.
    step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    chk("zero_count", {27'd0, count}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Back-to-back pushes drain in order with pointer wrap.
    for (int k = 1; k <= 9; k++) step(1'b1, 5'(k), 32'h100 + k, 5'(k), 5'(k - 1));
    step(1'b0, 5'd0, 32'd0, 5'd9, 5'd8);
    step(1'b0, 5'd0, 32'd0, 5'd9, 5'd8);

    rand_steps(300);

    // Reset in mid-cycle with an entry pending.
    step(1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd0);
    chk("pre_rst_wen", {31'd0, Write_EN}, 32'd1);
    in_valid = 1'b0;
    src1     = 5'd12;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    pend.delete();
    sb.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs("hold");
    rst = 1'b1;

    step(1'b1, 5'd3, 32'h0BADCAFE, 5'd12, 5'd3);
    chk("post_rst_dest", {27'd0, dest}, 32'd3);
    rand_steps(200);

    for (int k = 0; k < 4; k++) step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("sb_drained", sb.size(), 32'd0);
    if (n_wr == 0) chk("writes_seen", n_wr, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
